// File: rtl/ezusb_gpio_pkg.sv
// Shared types and helpers for the EZ-USB GPIO control stage.
package ezusb_gpio_pkg;

   localparam int GPIO_WIDTH = 4;

   // Per-line output pulse state
   typedef enum logic {
      PS_IDLE   = 1'b0,
      PS_ACTIVE = 1'b1
   } pulse_state_e;

   // Bits needed to hold any value 0..max_val
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// Single-line synchronizer, debounce filter and edge detector.
// A level change is accepted only after DEBOUNCE_CYCLES consecutive
// synchronized samples disagree with the current level.
module gpio_debounce_bit
   import ezusb_gpio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic gpio_in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // Next-state for the filter: count disagreeing samples, flip level on the last one
   always_comb begin
      sync_d  = gpio_in;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q;
            cnt_d   = '0;
            rise_d  = sync_q;
            fall_d  = ~sync_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   // State registers; reset clears everything without producing strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ezusb_gpio_ctl.sv
// GPIO control stage between user logic and the wired-or pad block.
// Inputs are synchronized, debounced and edge-detected per line; outputs
// are a static drive OR'ed with fixed-length, non-retriggerable pulses.
// Optional feature macro: GPIO_EVENT_LATCH_EN adds sticky edge events and irq.
// The event output is called event_flag because 'event' is a keyword.
module ezusb_gpio_ctl
   import ezusb_gpio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PULSE_CYCLES    = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [GPIO_WIDTH-1:0] gpio_in,
   output logic [GPIO_WIDTH-1:0] gpio_out,
   output logic [GPIO_WIDTH-1:0] level,
   output logic [GPIO_WIDTH-1:0] rise,
   output logic [GPIO_WIDTH-1:0] fall,
   input  logic [GPIO_WIDTH-1:0] drive,
   input  logic [GPIO_WIDTH-1:0] pulse_req,
   output logic [GPIO_WIDTH-1:0] pulse_busy
`ifdef GPIO_EVENT_LATCH_EN
   ,
   input  logic [GPIO_WIDTH-1:0] event_clr,
   output logic [GPIO_WIDTH-1:0] event_flag,
   output logic                  irq
`endif
);

   localparam int            PW        = cnt_width(PULSE_CYCLES);
   localparam logic [PW-1:0] PCNT_LOAD = PW'(PULSE_CYCLES - 1);

   // Input path: one filter per line
   for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_db
      gpio_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk    (clk),
         .reset  (reset),
         .gpio_in(gpio_in[g]),
         .level  (level[g]),
         .rise   (rise[g]),
         .fall   (fall[g])
      );
   end

   pulse_state_e          ps_q   [GPIO_WIDTH];
   pulse_state_e          ps_d   [GPIO_WIDTH];
   logic [PW-1:0]         pcnt_q [GPIO_WIDTH];
   logic [PW-1:0]         pcnt_d [GPIO_WIDTH];
   logic [GPIO_WIDTH-1:0] busy_q, busy_d;
   logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_out_d;

   // Pulse FSM next-state; requests are only honoured from IDLE
   always_comb begin
      for (int i = 0; i < GPIO_WIDTH; i++) begin
         ps_d[i]   = ps_q[i];
         pcnt_d[i] = pcnt_q[i];
         busy_d[i] = busy_q[i];
         case (ps_q[i])
            PS_IDLE: begin
               if (pulse_req[i]) begin
                  ps_d[i]   = PS_ACTIVE;
                  pcnt_d[i] = PCNT_LOAD;
                  busy_d[i] = 1'b1;
               end
            end
            PS_ACTIVE: begin
               if (pcnt_q[i] == '0) begin
                  ps_d[i]   = PS_IDLE;
                  busy_d[i] = 1'b0;
               end else begin
                  pcnt_d[i] = pcnt_q[i] - PW'(1);
                  busy_d[i] = 1'b1;
               end
            end
         endcase
      end
      // Uses next busy so gpio_out and pulse_busy rise and fall together
      gpio_out_d = drive | busy_d;
   end

   // Pulse FSM and output registers; reset aborts any pulse in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < GPIO_WIDTH; i++) begin
            ps_q[i]   <= PS_IDLE;
            pcnt_q[i] <= '0;
         end
         busy_q     <= '0;
         gpio_out_q <= '0;
      end else begin
         for (int i = 0; i < GPIO_WIDTH; i++) begin
            ps_q[i]   <= ps_d[i];
            pcnt_q[i] <= pcnt_d[i];
         end
         busy_q     <= busy_d;
         gpio_out_q <= gpio_out_d;
      end
   end

   assign pulse_busy = busy_q;
   assign gpio_out   = gpio_out_q;

`ifdef GPIO_EVENT_LATCH_EN
   logic [GPIO_WIDTH-1:0] event_q, event_d;
   logic                  irq_q, irq_d;

   // Sticky edge capture; a set in the same cycle as a clear takes priority
   always_comb begin
      event_d = (event_q & ~event_clr) | rise | fall;
      irq_d   = |event_d;
   end

   // Event and interrupt registers
   always_ff @(posedge clk) begin
      if (reset) begin
         event_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         event_q <= event_d;
         irq_q   <= irq_d;
      end
   end

   assign event_flag = event_q;
   assign irq        = irq_q;
`endif

endmodule

// File: tb/tb_ezusb_gpio_ctl.sv
// Self-checking bench for ezusb_gpio_ctl (default parameters).
// Reference model: a line's level flips when the last DEBOUNCE_CYCLES
// synchronized samples all disagree with it; a pulse is a remaining-cycle
// budget that can only be loaded when empty.
module tb_ezusb_gpio_ctl;

   localparam int DB = 16;
   localparam int PC = 256;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] gpio_in, drive, pulse_req;
   logic [3:0] gpio_out, level, rise, fall, pulse_busy;
`ifdef GPIO_EVENT_LATCH_EN
   logic [3:0] event_clr, event_flag;
   logic       irq;
`endif

   ezusb_gpio_ctl #(.DEBOUNCE_CYCLES(DB), .PULSE_CYCLES(PC)) dut (
      .clk       (clk),
      .reset     (reset),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .level     (level),
      .rise      (rise),
      .fall      (fall),
      .drive     (drive),
      .pulse_req (pulse_req),
      .pulse_busy(pulse_busy)
`ifdef GPIO_EVENT_LATCH_EN
      ,
      .event_clr (event_clr),
      .event_flag(event_flag),
      .irq       (irq)
`endif
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   logic [3:0]    m_sync, m_level, m_rise, m_fall, m_busy, m_out, m_evt;
   logic          m_irq;
   logic [DB-1:0] m_hist [4];
   int            m_rem  [4];

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // advance the model by one clock edge using the inputs present at that edge
   task automatic model_edge();
      if (reset) begin
         m_sync = '0; m_level = '0; m_rise = '0; m_fall = '0;
         m_busy = '0; m_out = '0; m_evt = '0; m_irq = 1'b0;
         for (int i = 0; i < 4; i++) begin
            m_hist[i] = '0;
            m_rem[i]  = 0;
         end
      end else begin
`ifdef GPIO_EVENT_LATCH_EN
         m_evt = (m_evt & ~event_clr) | m_rise | m_fall;
         m_irq = |m_evt;
`endif
         for (int i = 0; i < 4; i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            m_hist[i] = {m_hist[i][DB-2:0], m_sync[i]};
            if (m_hist[i] == {DB{~m_level[i]}}) begin
               m_level[i] = ~m_level[i];
               if (m_level[i]) m_rise[i] = 1'b1;
               else            m_fall[i] = 1'b1;
            end
            if (m_rem[i] > 0)      m_rem[i] = m_rem[i] - 1;
            else if (pulse_req[i]) m_rem[i] = PC;
            m_busy[i] = (m_rem[i] > 0);
         end
         m_sync = gpio_in;
         m_out  = drive | m_busy;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("level", level, m_level);
      chk("rise", rise, m_rise);
      chk("fall", fall, m_fall);
      chk("rise_fall_excl", rise & fall, 4'h0);
      chk("pulse_busy", pulse_busy, m_busy);
      chk("gpio_out", gpio_out, m_out);
`ifdef GPIO_EVENT_LATCH_EN
      chk("event", event_flag, m_evt);
      chk("irq", {3'b000, irq}, {3'b000, m_irq});
`endif
   endtask

   initial begin
      int first, cnt_a, cnt_b, r0, r3, other;
      reset = 1'b1; gpio_in = 4'hF; drive = 4'hF; pulse_req = 4'h0;
`ifdef GPIO_EVENT_LATCH_EN
      event_clr = 4'h0;
`endif
      // reset with everything asserted: outputs must stay 0
      repeat (3) step();
      chk("reset_level", level, 4'h0);
      chk("reset_gpio_out", gpio_out, 4'h0);

      // release: level appears 17 cycles later with a single rise strobe
      reset = 1'b0;
      first = -1; cnt_a = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (first < 0 && level == 4'hF) first = i;
         if (rise == 4'hF) cnt_a++;
      end
      chk_int("release_latency", first, 17);
      chk_int("release_rise_count", cnt_a, 1);

      gpio_in = 4'h0; drive = 4'h0;
      repeat (20) step();

      // 15-cycle glitch on line 2 is rejected
      cnt_a = 0;
      gpio_in[2] = 1'b1;
      repeat (15) begin step(); cnt_a += int'(level[2] | rise[2]); end
      gpio_in[2] = 1'b0;
      repeat (20) begin step(); cnt_a += int'(level[2] | rise[2]); end
      chk_int("glitch_reject", cnt_a, 0);

      // 16-cycle high is accepted after 17 cycles
      first = -1; cnt_a = 0;
      gpio_in[2] = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         if (i == 17) gpio_in[2] = 1'b0;
         step();
         if (first < 0 && level[2]) first = i;
         cnt_a += int'(rise[2]);
      end
      chk_int("accept_latency", first, 17);
      chk_int("accept_rise_count", cnt_a, 1);
      repeat (20) step();

      // pulse on line 1 with an ignored retrigger at cycle 100
      cnt_a = 0; cnt_b = 0;
      for (int i = 1; i <= 300; i++) begin
         pulse_req = (i == 1 || i == 100) ? 4'b0010 : 4'b0000;
         step();
         cnt_a += int'(pulse_busy[1]);
         cnt_b += int'(gpio_out[1]);
      end
      pulse_req = 4'h0;
      chk_int("pulse_busy_len", cnt_a, PC);
      chk_int("pulse_out_len", cnt_b, PC);

      // drive overlapping a pulse on line 0
      pulse_req = 4'b0001; drive = 4'b0001;
      step();
      pulse_req = 4'h0;
      repeat (259) step();
      chk("overlap_busy_done", pulse_busy, 4'h0);
      chk("overlap_drive_held", gpio_out, 4'b0001);
      drive = 4'h0;
      step();
      chk("drive_release", gpio_out, 4'h0);

      // independence: lines 3 and 0 rise 5 cycles apart
      r0 = -1; r3 = -1; other = 0;
      gpio_in = 4'b1000;
      for (int i = 1; i <= 30; i++) begin
         if (i == 6) gpio_in[0] = 1'b1;
         step();
         if (rise[3]) r3 = i;
         if (rise[0]) r0 = i;
         other += int'(rise[1] | rise[2] | fall[1] | fall[2]);
      end
      chk_int("indep_rise3", r3, 17);
      chk_int("indep_gap", r0 - r3, 5);
      chk_int("indep_others", other, 0);

`ifdef GPIO_EVENT_LATCH_EN
      // clear any events, then fall[3] coincident with a held clear
      event_clr = 4'hF;
      step();
      event_clr = 4'b1000;
      gpio_in[3] = 1'b0;
      first = -1;
      for (int i = 1; i <= 25 && first < 0; i++) begin
         step();
         if (fall[3]) first = i;
      end
      chk_int("evt_fall_seen", int'(first > 0), 1);
      step();
      chk("evt_set_wins", {3'b000, event_flag[3]}, 4'h1);
      chk("evt_irq_set", {3'b000, irq}, 4'h1);
      step();
      chk("evt_cleared", {3'b000, event_flag[3]}, 4'h0);
      chk("evt_irq_clr", {3'b000, irq}, 4'h0);
      event_clr = 4'h0;
`endif

      // randomized traffic including occasional resets
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 9) == 0) gpio_in[$urandom_range(0, 3)] ^= 1'b1;
         for (int b = 0; b < 4; b++) pulse_req[b] = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 49) == 0) drive = 4'($urandom);
`ifdef GPIO_EVENT_LATCH_EN
         for (int b = 0; b < 4; b++) event_clr[b] = ($urandom_range(0, 7) == 0);
`endif
         step();
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
